// File: rtl/data_path_if.sv
// Control and observation bundle between the external controller and the datapath.
// The controller drives the control word; the datapath returns the bus, PC, IR and debug taps.
interface data_path_if;
  logic        write;
  logic [4:0]  rdAddrA;
  logic [4:0]  rdAddrB;
  logic [4:0]  wrAddr;
  logic [63:0] K;
  logic [4:0]  FS;
  logic        C_in;
  logic        B_sel;
  logic        ramWrite;
  logic        PC_sel;
  logic [1:0]  PS;
  logic        IR_load;
  logic        AS;
  logic [1:0]  DS;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [31:0] IR_out;
  logic [63:0] DataBus;
  logic [63:0] PC_output;

  modport master (
    output write, rdAddrA, rdAddrB, wrAddr, K, FS, C_in, B_sel,
           ramWrite, PC_sel, PS, IR_load, AS, DS,
    input  r0, r1, r2, r3, r4, r5, r6, r7, IR_out, DataBus, PC_output
  );

  modport slave (
    input  write, rdAddrA, rdAddrB, wrAddr, K, FS, C_in, B_sel,
           ramWrite, PC_sel, PS, IR_load, AS, DS,
    output r0, r1, r2, r3, r4, r5, r6, r7, IR_out, DataBus, PC_output
  );
endinterface

// File: rtl/data_path.sv
// 64-bit single-cycle datapath: regfile, ALU, data RAM, PC and IR sharing one DataBus.
// All control comes from outside; X31 is the hard-wired zero register.
module data_path #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  data_path_if.slave  bus
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [63:0]   regs [32];
  logic [63:0]   mem  [RAM_WORDS];
  logic [63:0]   pc;
  logic [31:0]   ir;
  logic [63:0]   reg_a, reg_b;
  logic [63:0]   alu_a, alu_b, alu_y;
  logic [63:0]   pc_in, data_bus, ram_q;
  logic [AW-1:0] ram_addr;

  assign reg_a = (bus.rdAddrA == 5'd31) ? 64'd0 : regs[bus.rdAddrA];
  assign reg_b = (bus.rdAddrB == 5'd31) ? 64'd0 : regs[bus.rdAddrB];

  always_comb begin
    alu_a = bus.FS[0] ? ~reg_a : reg_a;
    alu_b = bus.B_sel ? bus.K : reg_b;
    if (bus.FS[1]) alu_b = ~alu_b;
    alu_y = 64'd0;
    case (bus.FS[4:2])
      3'b000:  alu_y = alu_a & alu_b;
      3'b001:  alu_y = alu_a | alu_b;
      3'b010:  alu_y = alu_a + alu_b + {63'd0, bus.C_in};
      3'b011:  alu_y = alu_a ^ alu_b;
      3'b100:  alu_y = alu_a << alu_b[5:0];
      3'b101:  alu_y = alu_a >> alu_b[5:0];
      default: alu_y = 64'd0;
    endcase
  end

  // Byte address to word index: drop the 3 byte-offset bits.
  assign ram_addr = bus.AS ? pc[AW+2:3] : alu_y[AW+2:3];
  assign ram_q    = mem[ram_addr];

  always_comb begin
    data_bus = 64'd0;
    case (bus.DS)
      2'b00:   data_bus = alu_y;
      2'b01:   data_bus = ram_q;
      2'b10:   data_bus = pc;
      default: data_bus = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else if (bus.write && bus.wrAddr != 5'd31) begin
      regs[bus.wrAddr] <= data_bus;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (bus.ramWrite) mem[ram_addr] <= reg_b;
  end

  assign pc_in = bus.PC_sel ? bus.K : reg_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= 64'd0;
    end else begin
      case (bus.PS)
        2'b00:   pc <= pc;
        2'b01:   pc <= pc + 64'd4;
        2'b10:   pc <= pc_in;
        default: pc <= pc + 64'd4 + (pc_in << 2);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ir <= 32'd0;
    else if (bus.IR_load) ir <= data_bus[31:0];
  end

  assign bus.DataBus   = data_bus;
  assign bus.PC_output = pc;
  assign bus.IR_out    = ir;
  assign bus.r0 = regs[0][15:0];
  assign bus.r1 = regs[1][15:0];
  assign bus.r2 = regs[2][15:0];
  assign bus.r3 = regs[3][15:0];
  assign bus.r4 = regs[4][15:0];
  assign bus.r5 = regs[5][15:0];
  assign bus.r6 = regs[6][15:0];
  assign bus.r7 = regs[7][15:0];
endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios with literal expectations,
// then randomized control words checked every cycle against a behavioural model.
module tb_data_path;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_path_if bus ();
  data_path #(.RAM_WORDS(256)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [63:0] m_reg [32];
  logic [63:0] m_mem [256];
  bit          m_valid [256];
  logic [63:0] m_pc;
  logic [31:0] m_ir;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
    m_pc = 64'd0;
    m_ir = 32'd0;
  endtask

  function automatic logic [63:0] rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : m_reg[a];
  endfunction

  function automatic logic [63:0] m_alu();
    logic [63:0] a, b;
    int sh;
    a = rd(bus.rdAddrA);
    b = bus.B_sel ? bus.K : rd(bus.rdAddrB);
    if (bus.FS[0]) a = ~a;
    if (bus.FS[1]) b = ~b;
    sh = int'(b % 64);
    case (bus.FS[4:2])
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b + 64'(bus.C_in);
      3'd3: return a ^ b;
      3'd4: return a << sh;
      3'd5: return a >> sh;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int m_addr();
    logic [63:0] s;
    s = bus.AS ? m_pc : m_alu();
    return int'((s / 8) % 256);
  endfunction

  function automatic logic [63:0] m_bus();
    case (bus.DS)
      2'd0: return m_alu();
      2'd1: return m_mem[m_addr()];
      2'd2: return m_pc;
      default: return 64'd0;
    endcase
  endfunction

  // Every state change is computed from pre-edge values before anything is committed.
  task automatic m_edge();
    logic [63:0] busv, in_v, rb;
    int ad;
    busv = m_bus();
    in_v = bus.PC_sel ? bus.K : rd(bus.rdAddrA);
    rb   = rd(bus.rdAddrB);
    ad   = m_addr();
    if (bus.write && bus.wrAddr != 5'd31) m_reg[bus.wrAddr] = busv;
    if (bus.ramWrite) begin
      m_mem[ad]   = rb;
      m_valid[ad] = 1'b1;
    end
    case (bus.PS)
      2'd1: m_pc = m_pc + 64'd4;
      2'd2: m_pc = in_v;
      2'd3: m_pc = m_pc + 64'd4 + in_v * 64'd4;
      default: ;
    endcase
    if (bus.IR_load) m_ir = busv[31:0];
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) m_edge();
    #1;
  endtask

  task automatic idle();
    bus.write = 0; bus.rdAddrA = 0; bus.rdAddrB = 0; bus.wrAddr = 0;
    bus.K = 0; bus.FS = 0; bus.C_in = 0; bus.B_sel = 0; bus.ramWrite = 0;
    bus.PC_sel = 0; bus.PS = 0; bus.IR_load = 0; bus.AS = 0; bus.DS = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (!(bus.DS == 2'd1 && !m_valid[m_addr()])) chk("bus", bus.DataBus, m_bus());
      chk("pc", bus.PC_output, m_pc);
      chk("ir", 64'(bus.IR_out), 64'(m_ir));
      chk("r0", 64'(bus.r0), 64'(m_reg[0][15:0]));
      chk("r1", 64'(bus.r1), 64'(m_reg[1][15:0]));
      chk("r2", 64'(bus.r2), 64'(m_reg[2][15:0]));
      chk("r3", 64'(bus.r3), 64'(m_reg[3][15:0]));
      chk("r4", 64'(bus.r4), 64'(m_reg[4][15:0]));
      chk("r5", 64'(bus.r5), 64'(m_reg[5][15:0]));
      chk("r6", 64'(bus.r6), 64'(m_reg[6][15:0]));
      chk("r7", 64'(bus.r7), 64'(m_reg[7][15:0]));
    end
  end

  initial begin
    idle();
    m_clear();
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 64'd0;
      m_valid[i] = 1'b0;
    end

    // Reset held across edges, then released with idle controls.
    repeat (3) cyc();
    chk("rst_pc", bus.PC_output, 64'd0);
    chk("rst_ir", 64'(bus.IR_out), 64'd0);
    chk("rst_r0", 64'(bus.r0), 64'd0);
    chk("rst_r7", 64'(bus.r7), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) cyc();
    chk("idle_pc", bus.PC_output, 64'd0);

    // Load PC from K and capture it into IR one edge later.
    bus.PS = 2'd2; bus.PC_sel = 1; bus.K = 64'd4; bus.DS = 2'd2; bus.IR_load = 1;
    cyc();
    chk("ld_pc", bus.PC_output, 64'd4);
    chk("ld_ir_old", 64'(bus.IR_out), 64'd0);
    cyc();
    chk("ld_ir", 64'(bus.IR_out), 64'd4);
    cyc();
    chk("ld_hold", bus.PC_output, 64'd4);

    bus.IR_load = 0; bus.PS = 2'd1;
    cyc(); chk("inc8", bus.PC_output, 64'd8);
    cyc(); chk("inc12", bus.PC_output, 64'd12);
    cyc(); chk("inc16", bus.PC_output, 64'd16);
    bus.PS = 2'd0;
    cyc(); chk("freeze", bus.PC_output, 64'd16);

    // Relative branch and wrap-around.
    bus.PS = 2'd2; bus.K = 64'd4; cyc();
    bus.PS = 2'd3; cyc();
    chk("br24", bus.PC_output, 64'd24);
    cyc();
    chk("br44", bus.PC_output, 64'd44);
    bus.PS = 2'd2; bus.K = 64'hFFFF_FFFF_FFFF_FFFC; cyc();
    bus.PS = 2'd1; cyc();
    chk("wrap", bus.PC_output, 64'd0);

    // ALU add/subtract through the regfile.
    idle();
    bus.FS = 5'b01000; bus.B_sel = 1; bus.rdAddrA = 31; bus.K = 64'd5;
    bus.write = 1; bus.wrAddr = 1;
    cyc(); chk("r1_5", 64'(bus.r1), 64'd5);
    bus.rdAddrA = 1; bus.K = 64'd3; bus.wrAddr = 2;
    cyc(); chk("r2_8", 64'(bus.r2), 64'd8);
    bus.write = 0; bus.FS = 5'b01010; bus.B_sel = 0; bus.rdAddrA = 2; bus.rdAddrB = 1; bus.C_in = 1;
    #1 chk("sub3", bus.DataBus, 64'd3);

    // RAM store, load back, and a discarded write to X31.
    bus.FS = 5'b01000; bus.B_sel = 1; bus.C_in = 0; bus.rdAddrA = 31; bus.K = 64'd8;
    bus.AS = 0; bus.rdAddrB = 2; bus.ramWrite = 1;
    cyc();
    bus.ramWrite = 0; bus.DS = 2'd1; bus.write = 1; bus.wrAddr = 3;
    #1 chk("ram_rd", bus.DataBus, 64'd8);
    cyc(); chk("r3_8", 64'(bus.r3), 64'd8);
    bus.wrAddr = 31; cyc();
    bus.write = 0; bus.DS = 2'd0; bus.K = 64'd0;
    #1 chk("x31_zero", bus.DataBus, 64'd0);
    cyc();

    // Randomized control words with occasional mid-cycle resets.
    for (int n = 0; n < 600; n++) begin
      bus.write = 1'($urandom); bus.rdAddrA = 5'($urandom); bus.rdAddrB = 5'($urandom);
      bus.wrAddr = 5'($urandom % 8); bus.K = {$urandom, $urandom}; bus.FS = 5'($urandom);
      bus.C_in = 1'($urandom); bus.B_sel = 1'($urandom); bus.ramWrite = 1'($urandom);
      bus.PC_sel = 1'($urandom); bus.PS = 2'($urandom); bus.IR_load = 1'($urandom);
      bus.AS = 1'($urandom); bus.DS = 2'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        bus.FS = 5'b01000; bus.B_sel = 1; bus.rdAddrA = 31; bus.AS = 0;
        bus.K = 64'(8 * $urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) bus.K = 64'($urandom_range(0, 70));
      if (bus.DS == 2'd1 && !m_valid[m_addr()]) bus.DS = 2'd0;
      if ($urandom_range(0, 39) == 0) begin
        #1 reset = 1'b1;
        m_clear();
        #1 reset = 1'b0;
        chk("mid_rst_pc", bus.PC_output, 64'd0);
        if (bus.DS == 2'd1 && !m_valid[m_addr()]) bus.DS = 2'd0;
      end
      cyc();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
